// File: rtl/tx_burst_sequencer.sv
// Burst sequencer: fetches one 32-bit word per beat and streams its low
// `size` bytes, LSB first, to the byte-wide I2C transmit engine.
module tx_burst_sequencer #(
    parameter int DATA_W  = 32,
    parameter int BURST_W = 7
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [BURST_W-1:0] cfg_burst_i,
    input  logic [3:0]         cfg_size_i,
    input  logic               cfg_ready_i,
    input  logic               start_i,
    input  logic               abort_i,
    input  logic [DATA_W-1:0]  word_data_i,
    input  logic               word_valid_i,
    output logic               word_ready_o,
    output logic [7:0]         byte_data_o,
    output logic               byte_valid_o,
    input  logic               byte_ready_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o,
    output logic [BURST_W-1:0] beat_cnt_o,
    output logic [1:0]         state_o
);

    // Handshakes: a word transfers on a rising edge where word_valid_i and
    // word_ready_o are both high; a byte likewise with byte_valid_o/byte_ready_i.
    // Ready/valid outputs are decoded from registered state only.

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_SEND  = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [BURST_W-1:0] burst_q, burst_d;
    logic [BURST_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [3:0]         size_q, size_d;
    logic [1:0]         idx_q, idx_d;
    logic [DATA_W-1:0]  word_q, word_d;
    logic               err_q, err_d;

    logic burst_legal;
    logic size_legal;
    logic last_byte;
    logic last_beat;

    // Legal bursts are the powers of two that fit the counter (1..64).
    assign burst_legal = (cfg_burst_i != '0) &&
                         ((cfg_burst_i & (cfg_burst_i - BURST_W'(1))) == '0);
    assign size_legal  = (cfg_size_i == 4'd1) || (cfg_size_i == 4'd2) ||
                         (cfg_size_i == 4'd4);

    assign last_byte = ({2'b00, idx_q} == (size_q - 4'd1));
    assign last_beat = ((beat_cnt_q + BURST_W'(1)) == burst_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            burst_q    <= '0;
            beat_cnt_q <= '0;
            size_q     <= '0;
            idx_q      <= '0;
            word_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            burst_q    <= burst_d;
            beat_cnt_q <= beat_cnt_d;
            size_q     <= size_d;
            idx_q      <= idx_d;
            word_q     <= word_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        burst_d    = burst_q;
        beat_cnt_d = beat_cnt_q;
        size_d     = size_q;
        idx_d      = idx_q;
        word_d     = word_q;
        err_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (cfg_ready_i && burst_legal && size_legal) begin
                        burst_d    = cfg_burst_i;
                        size_d     = cfg_size_i;
                        beat_cnt_d = '0;
                        state_d    = S_FETCH;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_FETCH: begin
                if (word_valid_i) begin
                    word_d  = word_data_i;
                    idx_d   = 2'd0;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (byte_ready_i) begin
                    if (!last_byte) begin
                        idx_d = idx_q + 2'd1;
                    end else begin
                        beat_cnt_d = beat_cnt_q + BURST_W'(1);
                        state_d    = last_beat ? S_DONE : S_FETCH;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort wins over any progress; a byte in flight is treated as unsent.
        if (abort_i && (state_q != S_IDLE)) begin
            state_d    = S_IDLE;
            beat_cnt_d = beat_cnt_q;
            idx_d      = idx_q;
        end
    end

    assign word_ready_o = (state_q == S_FETCH);
    assign byte_valid_o = (state_q == S_SEND);
    assign busy_o       = (state_q != S_IDLE);
    assign done_o       = (state_q == S_DONE);
    assign err_o        = err_q;
    assign beat_cnt_o   = beat_cnt_q;
    assign state_o      = state_q;
    assign byte_data_o  = (state_q == S_SEND) ? word_q[{idx_q, 3'b000} +: 8] : 8'h00;

endmodule
